uart_bus_bridge: RTL
====================

Name: uart_bus_bridge

Overview:
- UART-driven bus initiator: receives command frames from a host PC on UART_RX, executes single 32-bit reads/writes on the CPU-side peripheral bus (rd/wr/addr/wdata/rdata), and returns responses on UART_TX.
- Sits beside the CPU as a debug/loader master, with arbitration through bus_req/bus_gnt.
- UART format: 8N1, LSB first, idle high.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600); legal range 16 to 65535.
- TIMEOUT_CLKS, 2000000, clk cycles of RX inactivity before a partial frame is dropped (used only with BRIDGE_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- UART_RX  input  1  serial in, asynchronous; double-flop synchronised internally.
- UART_TX  output  1  serial out.
- bus_req  output  1  bridge requests the bus.
- bus_gnt  input  1  arbiter grant.
- rd  output  1  bus read strobe.
- wr  output  1  bus write strobe.
- addr  output  32  bus address.
- wdata  output  32  bus write data.
- rdata  input  32  bus read data; combinational from the slave in the same cycle as rd.
- busy  output  1  high whenever the command FSM is not in IDLE.
- frame_err  output  1  one-cycle pulse on an RX stop-bit error.

Behaviour:
- Reset (reset=0 at a clk edge) values:
  - UART_TX=1; bus_req=0, rd=0, wr=0, addr=0, wdata=0, busy=0, frame_err=0.
  - All FSMs go to IDLE; counters clear. An in-flight TX byte is truncated (line returns high).
- RX:
  - Falling edge on the synchronised RX starts a frame. Wait CLKS_PER_BIT/2 (integer divide), then re-check start bit; if high, treat as a glitch and return to idle.
  - Sample 8 data bits, then the stop bit, at CLKS_PER_BIT intervals.
  - Stop=1: rx_valid pulses 1 cycle with the byte.
  - Stop=0: byte discarded, frame_err pulses 1 cycle, command FSM returns to IDLE.
- TX:
  - Start bit (0), 8 data bits LSB first, stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
  - tx_ready is high only in TX idle. A new byte loads the cycle tx_ready is seen, so back-to-back bytes have no extra idle gap.
- Command FSM states: IDLE, ADDR, DATA, REQ, XFER, RESP.
  - IDLE: byte 0x57 'W' -> ADDR (write); 0x52 'R' -> ADDR (read); any other byte -> queue reply 0x3F '?', stay IDLE.
  - ADDR: collect 4 bytes MSB first into addr. Write -> DATA; read -> REQ.
  - DATA: collect 4 bytes MSB first into wdata -> REQ.
  - REQ: bus_req=1. Hold until a cycle with bus_gnt=1 -> XFER.
  - XFER: exactly one cycle, with rd or wr =1 (never both) and bus_req still 1. On read, rdata is captured at the end of this cycle. Next state RESP; bus_req, rd and wr drop to 0 on the following edge.
  - RESP: write sends 0x4B 'K'; read sends rdata as 4 bytes MSB first. Return to IDLE after the last byte is handed to TX.
  - Bytes arriving during REQ/XFER/RESP are ignored; no queueing.
- bus_gnt:
  - If bus_gnt drops while in REQ, keep waiting.
  - bus_gnt is a don't-care outside REQ/XFER.
- addr/wdata hold their values after a transfer until the next command overwrites them.
- rd and wr are each asserted for exactly one cycle per command.

Optional Feature:
- Macro BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM is in ADDR or DATA and clears on each rx_valid.
  - Reaching TIMEOUT_CLKS aborts to IDLE, sends 0x54 'T', and issues no bus cycle.
- Undefined: no counter; a partial frame waits indefinitely (only reset or a framing error clears it).

Test Plan (CLKS_PER_BIT=16, TIMEOUT_CLKS=1000, bus_gnt tied 1 unless stated):
- Write: host sends 57 40 00 00 0C 00 00 00 A5 -> exactly one cycle of wr=1 with addr=0x4000000C, wdata=0x000000A5; then UART_TX returns byte 0x4B.
- Read: host sends 52 40 00 00 10, slave drives rdata=0x0000003C during the rd cycle -> rd high exactly 1 cycle with addr=0x40000010; TX returns 00 00 00 3C in that order.
- Grant stall: bus_gnt=0 for 50 cycles after a read frame -> bus_req held high, rd=0 throughout; rd pulses the cycle after bus_gnt rises; reply still correct.
- Errors:
  - Host sends 0x13 -> reply 0x3F.
  - Byte with stop bit forced 0 -> frame_err pulse, no bus cycle, busy=0.
  - 1-cycle low glitch on UART_RX -> no rx_valid.
- Reset mid-operation: reset=0 during DATA byte 2 and during TX of 0x4B -> next edge UART_TX=1, busy=0, rd=wr=0; a subsequent full write frame executes normally.
- BRIDGE_TIMEOUT_EN defined: send 57 40 00, then idle 1000 cycles -> reply 0x54, no wr. With the macro undefined, the same stimulus gives no reply and busy stays 1.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// UART-driven debug bus master: 'W'/'R' command frames in, single 32-bit bus cycles out, replies on TX.
// Optional RX inactivity timeout on partial frames: define BRIDGE_TIMEOUT_EN.
module uart_bus_bridge #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int TIMEOUT_CLKS = 2000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        UART_RX,
   output logic        UART_TX,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic        rd,
   output logic        wr,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic        busy,
   output logic        frame_err
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   // The final stop-bit cycle is spent in TX idle so a back-to-back byte loads with no gap.
   localparam logic [15:0] STOP_LAST = 16'(CLKS_PER_BIT - 2);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_e;
   typedef enum logic [2:0] {C_IDLE, C_ADDR, C_DATA, C_REQ, C_XFER, C_RESP} cmd_state_e;

   // ---------------- RX ----------------
   logic       rx_s1_q, rx_s2_q, rx_s3_q;
   rx_state_e  rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0] rx_bit_q, rx_bit_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic       rx_valid_q, rx_valid_d;
   logic       frame_err_q, frame_err_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_s3_q     <= 1'b1;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_s1_q     <= UART_RX;
         rx_s2_q     <= rx_s1_q;
         rx_s3_q     <= rx_s2_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q + 16'd1;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_s3_q && !rx_s2_q) rx_state_d = RX_START;
         end
         RX_START: if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d    = '0;
            rx_state_d  = RX_IDLE;
            rx_valid_d  = rx_s2_q;
            frame_err_d = !rx_s2_q;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- TX ----------------
   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [8:0]  tx_shift_q, tx_shift_d;
   logic [3:0]  tx_left_q, tx_left_d;
   logic        tx_line_q, tx_line_d;
   logic        tx_ready, tx_start;
   logic [7:0]  tx_byte;

   assign tx_ready = (tx_state_q == TX_IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_shift_q <= '1;
         tx_left_q  <= '0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_shift_q <= tx_shift_d;
         tx_left_q  <= tx_left_d;
         tx_line_q  <= tx_line_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      tx_shift_d = tx_shift_q;
      tx_left_d  = tx_left_q;
      tx_line_d  = tx_line_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d  = '0;
            tx_line_d = 1'b1;
            if (tx_start) begin
               tx_state_d = TX_BUSY;
               tx_line_d  = 1'b0;
               tx_shift_d = {1'b1, tx_byte};
               tx_left_d  = 4'd9;
            end
         end
         TX_BUSY: begin
            if (tx_left_q == 4'd0) begin
               if (tx_cnt_q == STOP_LAST) begin
                  tx_state_d = TX_IDLE;
                  tx_cnt_d   = '0;
               end
            end else if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_line_d  = tx_shift_q[0];
               tx_shift_d = {1'b1, tx_shift_q[8:1]};
               tx_left_d  = tx_left_q - 4'd1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // ---------------- command FSM ----------------
   cmd_state_e  cmd_q, cmd_d;
   logic        is_wr_q, is_wr_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [1:0]  resp_idx_q, resp_idx_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic        pend_q, pend_d;
   logic [7:0]  pend_byte_q, pend_byte_d;
   logic        timeout_hit;
   logic [7:0]  resp_byte;

`ifdef BRIDGE_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CLKS - 1);
   logic [31:0] to_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset || rx_valid_q || !(cmd_q == C_ADDR || cmd_q == C_DATA)) to_cnt_q <= '0;
      else                                                                to_cnt_q <= to_cnt_q + 32'd1;
   end

   assign timeout_hit = (cmd_q == C_ADDR || cmd_q == C_DATA) && (to_cnt_q == TO_LAST);
`else
   // Counter compiled out: nothing ever times out (parameter referenced only to keep it live).
   assign timeout_hit = (TIMEOUT_CLKS < 0);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         cmd_q       <= C_IDLE;
         is_wr_q     <= 1'b0;
         byte_cnt_q  <= '0;
         resp_idx_q  <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         pend_q      <= 1'b0;
         pend_byte_q <= '0;
      end else begin
         cmd_q       <= cmd_d;
         is_wr_q     <= is_wr_d;
         byte_cnt_q  <= byte_cnt_d;
         resp_idx_q  <= resp_idx_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         pend_q      <= pend_d;
         pend_byte_q <= pend_byte_d;
      end
   end

   always_comb begin
      case (resp_idx_q)
         2'd0:    resp_byte = rdata_q[31:24];
         2'd1:    resp_byte = rdata_q[23:16];
         2'd2:    resp_byte = rdata_q[15:8];
         default: resp_byte = rdata_q[7:0];
      endcase
   end

   always_comb begin
      cmd_d       = cmd_q;
      is_wr_d     = is_wr_q;
      byte_cnt_d  = byte_cnt_q;
      resp_idx_d  = resp_idx_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      pend_d      = pend_q;
      pend_byte_d = pend_byte_q;
      tx_start    = 1'b0;
      tx_byte     = 8'h00;

      // Single-byte replies ('?', 'T') go out ahead of any multi-byte response.
      if (pend_q) begin
         tx_start = tx_ready;
         tx_byte  = pend_byte_q;
         if (tx_ready) pend_d = 1'b0;
      end else if (cmd_q == C_RESP) begin
         tx_start = tx_ready;
         tx_byte  = is_wr_q ? 8'h4B : resp_byte;
         if (tx_ready) begin
            if (is_wr_q || resp_idx_q == 2'd3) cmd_d = C_IDLE;
            else                               resp_idx_d = resp_idx_q + 2'd1;
         end
      end

      case (cmd_q)
         C_IDLE: if (rx_valid_q) begin
            byte_cnt_d = '0;
            if (rx_shift_q == 8'h57 || rx_shift_q == 8'h52) begin
               cmd_d   = C_ADDR;
               is_wr_d = (rx_shift_q == 8'h57);
            end else begin
               pend_d      = 1'b1;
               pend_byte_d = 8'h3F;
            end
         end
         C_ADDR, C_DATA: begin
            if (frame_err_q) begin
               cmd_d = C_IDLE;
            end else if (timeout_hit) begin
               cmd_d       = C_IDLE;
               pend_d      = 1'b1;
               pend_byte_d = 8'h54;
            end else if (rx_valid_q) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (cmd_q == C_ADDR) addr_d  = {addr_q[23:0], rx_shift_q};
               else                 wdata_d = {wdata_q[23:0], rx_shift_q};
               if (byte_cnt_q == 2'd3)
                  cmd_d = (cmd_q == C_ADDR && is_wr_q) ? C_DATA : C_REQ;
            end
         end
         C_REQ:  if (bus_gnt) cmd_d = C_XFER;
         C_XFER: begin
            cmd_d      = C_RESP;
            resp_idx_d = '0;
            if (!is_wr_q) rdata_d = rdata;
         end
         default: ;
      endcase
   end

   assign UART_TX   = tx_line_q;
   assign busy      = (cmd_q != C_IDLE);
   assign bus_req   = (cmd_q == C_REQ) || (cmd_q == C_XFER);
   assign rd        = (cmd_q == C_XFER) && !is_wr_q;
   assign wr        = (cmd_q == C_XFER) && is_wr_q;
   assign addr      = addr_q;
   assign wdata     = wdata_q;
   assign frame_err = frame_err_q;

endmodule
